// File: rtl/b64_pkg.sv
// b64_pkg: shared constants and FSM state type for the Base64 UART frame path.
package b64_pkg;

    localparam int B64_NCHAR = 80;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        TERM = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/b64_frame_tx.sv
// b64_frame_tx: captures one Base64 frame on start and streams it byte by byte over valid/ready.
// Define B64_CRLF_EN to append a CR/LF terminator after every frame.
module b64_frame_tx
    import b64_pkg::*;
#(
    parameter int NCHAR = B64_NCHAR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NCHAR*8-1:0] frame_in,
    input  logic               tx_ready,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    output logic               busy,
    output logic               done
);

    localparam int FW = NCHAR * 8;
    localparam int CW = (NCHAR > 1) ? $clog2(NCHAR) : 1;

    state_t        state_q, state_d;
    logic [FW-1:0] shreg_q, shreg_d;
    logic [CW-1:0] cnt_q, cnt_d;
`ifdef B64_CRLF_EN
    logic          term_q, term_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef B64_CRLF_EN
            term_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef B64_CRLF_EN
            term_q  <= term_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
`ifdef B64_CRLF_EN
        term_d   = term_q;
`endif
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = frame_in;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = shreg_q[FW-1 -: 8];
                if (tx_ready) begin
                    shreg_d = shreg_q << 8;
                    // The counter holds on the last character so it never wraps.
                    if (cnt_q == CW'(NCHAR - 1)) begin
`ifdef B64_CRLF_EN
                        state_d = TERM;
`else
                        state_d = DONE;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef B64_CRLF_EN
            TERM: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = term_q ? CHAR_LF : CHAR_CR;
                if (tx_ready) begin
                    term_d  = ~term_q;
                    state_d = term_q ? DONE : TERM;
                end
            end
`endif
            DONE: begin
                done = 1'b1;
                // A start in the completion cycle chains straight into the next frame.
                if (start) begin
                    shreg_d = frame_in;
                    cnt_d   = '0;
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
